// File: rtl/z80_wb_bridge_p.sv
// rtl/z80_wb_bridge_p.sv - Z80 pin bus to Wishbone classic master bridge with paging, waits, INTA and timeout
module z80_wb_bridge_p #(
    parameter int                  WB_ADR_W    = 24,
    parameter int                  PAGE_W      = 8,
    parameter int                  IO_A_W      = 8,
    parameter logic [WB_ADR_W-1:0] IO_BASE     = 24'hFF0000,
    parameter logic [7:0]          INT_VECTOR  = 8'hFF,
    parameter int                  TIMEOUT_CYC = 255
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                nM1,
    input  logic                nMREQ,
    input  logic                nIORQ,
    input  logic                nRD,
    input  logic                nWR,
    input  logic                nRFSH,
    input  logic [15:0]         A,
    input  logic [7:0]          D_i,
    output logic [7:0]          D_o,
    output logic                D_oe,
    output logic                nWAIT,
    input  logic [PAGE_W-1:0]   page,
    output logic                wb_cyc_o,
    output logic                wb_stb_o,
    output logic                wb_we_o,
    output logic [WB_ADR_W-1:0] wb_adr_o,
    output logic [7:0]          wb_dat_o,
    input  logic [7:0]          wb_dat_i,
    output logic                wb_sel_o,
    input  logic                wb_ack_i,
    output logic                bus_err
);

    localparam int MEM_W = PAGE_W + 16;
    localparam int TO_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT_CYC > 0) ? TO_W'(TIMEOUT_CYC - 1) : '0;

    typedef enum logic [1:0] {IDLE, BUS, HOLD} state_t;

    state_t              state, state_next;
    logic                prev_mem, prev_io, prev_inta;
    logic [7:0]          rdata;
    logic                rd_op;
    logic [TO_W-1:0]     tcnt;
    logic [MEM_W-1:0]    mem_full;
    logic [WB_ADR_W-1:0] mem_adr;
    logic [WB_ADR_W-1:0] io_adr;

    logic mem_rq, io_rq, inta;
    logic mem_rise, io_rise, inta_rise, start, timeout_hit;

    assign mem_rq    = ~nMREQ & nRFSH & (~nRD | ~nWR);
    assign io_rq     = ~nIORQ & nM1 & (~nRD | ~nWR);
    assign inta      = ~nIORQ & ~nM1;
    assign mem_rise  = mem_rq & ~prev_mem;
    assign io_rise   = io_rq & ~prev_io;
    assign inta_rise = inta & ~prev_inta;
    assign start     = (state == IDLE) & (mem_rise | io_rise);

    // A timed-out cycle is the TIMEOUT_CYC-th BUS cycle; counter holds cycles already spent
    assign timeout_hit = (TIMEOUT_CYC != 0) && (state == BUS) && (tcnt == TO_LAST);

    assign mem_full = {page, A};
    generate
        if (MEM_W >= WB_ADR_W) begin : g_mem_trunc
            assign mem_adr = mem_full[WB_ADR_W-1:0];
        end else begin : g_mem_ext
            assign mem_adr = {{(WB_ADR_W - MEM_W){1'b0}}, mem_full};
        end
    endgenerate

    assign io_adr = IO_BASE | {{(WB_ADR_W - IO_A_W){1'b0}}, A[IO_A_W-1:0]};

    assign wb_sel_o = wb_cyc_o;
    assign D_o      = rdata;
    assign D_oe     = (state == HOLD) & rd_op & (~nRD | ~nIORQ);

    // Stall the Z80 from the request cycle until the Wishbone cycle has finished
    assign nWAIT = RESET | ~(((state == IDLE) & (mem_rise | io_rise)) |
                             ((state == BUS) & (mem_rq | io_rq)));

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (mem_rise | io_rise) begin
                    state_next = BUS;
                end else if (inta_rise) begin
                    state_next = HOLD;
                end
            end
            BUS: begin
                if (wb_ack_i | timeout_hit) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (~(mem_rq | io_rq | inta)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Wishbone master registers, read-data capture, timeout counter and error pulse.
    // Edge history resets to "active" so strobes held through reset never start a cycle.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            prev_mem  <= 1'b1;
            prev_io   <= 1'b1;
            prev_inta <= 1'b1;
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            wb_we_o   <= 1'b0;
            wb_adr_o  <= '0;
            wb_dat_o  <= 8'h00;
            rdata     <= 8'hFF;
            rd_op     <= 1'b0;
            tcnt      <= '0;
            bus_err   <= 1'b0;
        end else begin
            prev_mem  <= mem_rq;
            prev_io   <= io_rq;
            prev_inta <= inta;
            bus_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                        wb_we_o  <= ~nWR;
                        wb_adr_o <= mem_rise ? mem_adr : io_adr;
                        wb_dat_o <= D_i;
                        rd_op    <= nWR;
                        tcnt     <= '0;
                    end else if (inta_rise) begin
                        rdata <= INT_VECTOR;
                        rd_op <= 1'b1;
                    end
                end
                BUS: begin
                    if (wb_ack_i) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        if (!wb_we_o) begin
                            rdata <= wb_dat_i;
                        end
                    end else if (timeout_hit) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        rdata    <= 8'hFF;
                        bus_err  <= 1'b1;
                    end else if (tcnt != {TO_W{1'b1}}) begin
                        tcnt <= tcnt + TO_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_z80_wb_bridge_p.sv
// tb/tb_z80_wb_bridge_p.sv - scoreboard bench for z80_wb_bridge_p
module tb_z80_wb_bridge_p;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        nM1, nMREQ, nIORQ, nRD, nWR, nRFSH;
    logic [15:0] A;
    logic [7:0]  D_i;
    logic [7:0]  D_o;
    logic        D_oe, nWAIT;
    logic [7:0]  page;
    logic        wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_ack_i, bus_err;
    logic [23:0] wb_adr_o;
    logic [7:0]  wb_dat_o, wb_dat_i;

    typedef struct packed {
        logic        we;
        logic [23:0] adr;
        logic [7:0]  dat;
    } wb_exp_t;

    wb_exp_t    wb_q[$];
    logic [7:0] rd_q[$];

    int tests = 0;
    int fails = 0;
    int ack_delay = 0;
    int acnt = 0;
    logic [7:0] slave_dat = 8'h00;
    int wb_starts = 0;
    int cyc_cycles = 0;
    int err_pulses = 0;
    logic cyc_q = 1'b0, err_q = 1'b0, doe_q = 1'b0;

    z80_wb_bridge_p dut (
        .CLK(CLK), .RESET(RESET), .nM1(nM1), .nMREQ(nMREQ), .nIORQ(nIORQ),
        .nRD(nRD), .nWR(nWR), .nRFSH(nRFSH), .A(A), .D_i(D_i), .D_o(D_o),
        .D_oe(D_oe), .nWAIT(nWAIT), .page(page), .wb_cyc_o(wb_cyc_o),
        .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
        .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_sel_o(wb_sel_o),
        .wb_ack_i(wb_ack_i), .bus_err(bus_err)
    );

    always #5 CLK = ~CLK;

    assign wb_dat_i = slave_dat;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Slave: ack in BUS cycle ack_delay+1
    always @(posedge CLK) begin
        #1;
        if (wb_cyc_o && wb_stb_o && !wb_ack_i) begin
            if (acnt >= ack_delay) wb_ack_i = 1'b1;
            else acnt++;
        end else begin
            wb_ack_i = 1'b0;
            acnt = 0;
        end
    end

    // Monitor: pops expected WB request at cycle start and expected read data at D_oe rise
    always @(negedge CLK) begin
        if (wb_cyc_o && !cyc_q) begin
            wb_starts++;
            if (wb_q.size() == 0) begin
                check("wb_unexpected_cycle", 1, 0);
            end else begin
                wb_exp_t e;
                e = wb_q.pop_front();
                check("wb_adr", {8'h0, wb_adr_o}, {8'h0, e.adr});
                check("wb_we", {31'h0, wb_we_o}, {31'h0, e.we});
                check("wb_sel", {31'h0, wb_sel_o}, 1);
                check("wb_stb", {31'h0, wb_stb_o}, 1);
                if (e.we) check("wb_dat", {24'h0, wb_dat_o}, {24'h0, e.dat});
            end
        end
        if (wb_cyc_o) cyc_cycles++;
        if (bus_err) begin
            err_pulses++;
            if (err_q) check("bus_err_width", 2, 1);
        end
        if (D_oe && !doe_q) begin
            if (rd_q.size() == 0) begin
                check("rd_unexpected_doe", 1, 0);
            end else begin
                logic [7:0] r;
                r = rd_q.pop_front();
                check("rd_data", {24'h0, D_o}, {24'h0, r});
            end
        end
        cyc_q = wb_cyc_o;
        err_q = bus_err;
        doe_q = D_oe;
    end

    task automatic release_bus();
        nMREQ = 1'b1; nIORQ = 1'b1; nRD = 1'b1; nWR = 1'b1; nM1 = 1'b1; nRFSH = 1'b1;
    endtask

    task automatic z80_op(input bit is_mem, input bit is_wr, input logic [7:0] pg,
                          input logic [15:0] a, input logic [7:0] d,
                          input int exp_stall, input string name);
        int stall;
        stall = 0;
        @(posedge CLK); #1;
        cyc_cycles = 0;
        page = pg; A = a; D_i = d;
        nRD = is_wr; nWR = !is_wr;
        if (is_mem) nMREQ = 1'b0; else nIORQ = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge CLK);
            if (nWAIT) break;
            stall++;
        end
        check({name, "_stall"}, stall, exp_stall);
        check({name, "_doe"}, {31'h0, D_oe}, {31'h0, !is_wr});
        @(posedge CLK); #1;
        release_bus();
        repeat (2) @(posedge CLK);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int starts0, errs0;
        RESET = 1'b1;
        release_bus();
        A = 16'h0; D_i = 8'h0; page = 8'h0; wb_ack_i = 1'b0;
        repeat (3) @(posedge CLK);
        #1 RESET = 1'b0;
        @(negedge CLK);
        check("rst_cyc", {31'h0, wb_cyc_o}, 0);
        check("rst_stb", {31'h0, wb_stb_o}, 0);
        check("rst_we", {31'h0, wb_we_o}, 0);
        check("rst_adr", {8'h0, wb_adr_o}, 0);
        check("rst_dat", {24'h0, wb_dat_o}, 0);
        check("rst_doe", {31'h0, D_oe}, 0);
        check("rst_nwait", {31'h0, nWAIT}, 1);
        check("rst_err", {31'h0, bus_err}, 0);
        check("rst_do", {24'h0, D_o}, 32'hFF);

        // Memory read, ack 3 cycles after stb
        ack_delay = 3; slave_dat = 8'hA5;
        wb_q.push_back('{we: 1'b0, adr: 24'h123456, dat: 8'h00});
        rd_q.push_back(8'hA5);
        z80_op(1, 0, 8'h12, 16'h3456, 8'h00, 5, "memrd");

        // Slave never acks
        ack_delay = 1000; slave_dat = 8'h11;
        errs0 = err_pulses;
        wb_q.push_back('{we: 1'b0, adr: 24'h001000, dat: 8'h00});
        rd_q.push_back(8'hFF);
        z80_op(1, 0, 8'h00, 16'h1000, 8'h00, 256, "tmo");
        check("tmo_cyc_cycles", cyc_cycles, 255);
        check("tmo_err_pulses", err_pulses - errs0, 1);

        // IO write
        ack_delay = 1;
        starts0 = wb_starts;
        wb_q.push_back('{we: 1'b1, adr: 24'hFF0042, dat: 8'h3C});
        z80_op(0, 1, 8'h99, 16'h7F42, 8'h3C, 3, "iowr");
        check("iowr_starts", wb_starts - starts0, 1);
        check("iowr_cyc_cycles", cyc_cycles, 2);

        // Ack on exactly the timeout cycle
        ack_delay = 254; slave_dat = 8'h5A;
        errs0 = err_pulses;
        wb_q.push_back('{we: 1'b0, adr: 24'h010002, dat: 8'h00});
        rd_q.push_back(8'h5A);
        z80_op(1, 0, 8'h01, 16'h0002, 8'h00, 256, "coinc");
        check("coinc_cyc_cycles", cyc_cycles, 255);
        check("coinc_no_err", err_pulses - errs0, 0);

        // Refresh cycles then interrupt acknowledge
        starts0 = wb_starts;
        @(posedge CLK); #1;
        cyc_cycles = 0;
        A = 16'h0055; nMREQ = 1'b0; nRFSH = 1'b0;
        @(negedge CLK); check("rfsh_nwait0", {31'h0, nWAIT}, 1);
        @(posedge CLK); #1 nRD = 1'b0;
        @(negedge CLK); check("rfsh_nwait1", {31'h0, nWAIT}, 1);
        @(negedge CLK); check("rfsh_nwait2", {31'h0, nWAIT}, 1);
        @(posedge CLK); #1 release_bus();
        rd_q.push_back(8'hFF);
        @(posedge CLK); #1 nIORQ = 1'b0; nM1 = 1'b0;
        repeat (3) @(negedge CLK);
        check("inta_doe", {31'h0, D_oe}, 1);
        check("inta_nwait", {31'h0, nWAIT}, 1);
        @(posedge CLK); #1 release_bus();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rfsh_inta_no_wb", wb_starts - starts0, 0);
        check("rfsh_inta_cyc", cyc_cycles, 0);

        // Reset during the 2nd BUS cycle of a write
        ack_delay = 1000;
        errs0 = err_pulses;
        wb_q.push_back('{we: 1'b1, adr: 24'h000100, dat: 8'h77});
        @(posedge CLK); #1;
        page = 8'h00; A = 16'h0100; D_i = 8'h77; nMREQ = 1'b0; nWR = 1'b0;
        @(posedge CLK);
        @(posedge CLK); #1 RESET = 1'b1;
        @(posedge CLK); #1 RESET = 1'b0;
        @(negedge CLK);
        check("rstmid_cyc", {31'h0, wb_cyc_o}, 0);
        check("rstmid_stb", {31'h0, wb_stb_o}, 0);
        check("rstmid_we", {31'h0, wb_we_o}, 0);
        check("rstmid_nwait", {31'h0, nWAIT}, 1);
        check("rstmid_err", err_pulses - errs0, 0);
        @(posedge CLK); #1 release_bus();
        repeat (2) @(posedge CLK);

        // Fresh zero-wait read after reset
        ack_delay = 0; slave_dat = 8'h81;
        wb_q.push_back('{we: 1'b0, adr: 24'h120001, dat: 8'h00});
        rd_q.push_back(8'h81);
        z80_op(1, 0, 8'h12, 16'h0001, 8'h00, 2, "fresh");

        repeat (2) @(negedge CLK);
        check("wb_q_drained", wb_q.size(), 0);
        check("rd_q_drained", rd_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
